// File: rtl/mac_preactivation.sv
// Streaming multiply-accumulate producing one rounded, saturated pre-activation per VEC_LEN beats.
// Optional macro MAC_PREACTIVATION_SAT_FLAG_EN adds the out_sat clip flag.
module mac_preactivation #(
    parameter int unsigned W_X     = 8,
    parameter int unsigned X_F     = 6,
    parameter int unsigned W_W     = 8,
    parameter int unsigned W_F     = 6,
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned W_IN    = 8,
    parameter int unsigned IN_I    = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [W_X-1:0]  in_x,
    input  logic signed [W_W-1:0]  in_w,
    input  logic signed [W_IN-1:0] in_bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic        [W_IN-1:0] out_data
`ifdef MAC_PREACTIVATION_SAT_FLAG_EN
    ,
    output logic                   out_sat
`endif
);

    localparam int unsigned IN_F  = W_IN - IN_I;
    localparam int unsigned PF    = X_F + W_F;
    localparam int unsigned SH    = PF - IN_F;
    localparam int unsigned P_W   = W_X + W_W;
    localparam int unsigned CNT_W = $clog2(VEC_LEN);
    localparam int unsigned ACC_W = P_W + CNT_W + 1;
    localparam int unsigned R_W   = ACC_W + 1;

    localparam logic signed [R_W-1:0] MAX_V = R_W'((1 << (W_IN - 1)) - 1);
    localparam logic signed [R_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  bias_al;
    logic signed [R_W-1:0]    res;
    logic                     sat_hi;
    logic                     sat_lo;
    logic                     last_beat;
    logic                     out_valid_q;
    logic [W_IN-1:0]          out_data_q;
    logic [W_IN-1:0]          out_data_d;

    // Running sum including this beat; beat 0 restarts from the aligned bias.
    always_comb begin
        prod      = P_W'(in_x) * P_W'(in_w);
        bias_al   = ACC_W'(in_bias) <<< SH;
        acc_d     = ((cnt_q == '0) ? bias_al : acc_q) + ACC_W'(prod);
        last_beat = (cnt_q == CNT_W'(VEC_LEN - 1));
    end

    // Round half up into the output fraction; one spare bit absorbs the rounding add.
    generate
        if (SH > 0) begin : g_round
            localparam logic signed [R_W-1:0] HALF = R_W'(1) <<< (SH - 1);
            logic signed [R_W-1:0] sum_rnd;
            assign sum_rnd = R_W'(acc_d) + HALF;
            assign res     = sum_rnd >>> SH;
        end else begin : g_no_round
            assign res = R_W'(acc_d);
        end
    endgenerate

    always_comb begin
        sat_hi     = (res > MAX_V);
        sat_lo     = (res < MIN_V);
        out_data_d = res[W_IN-1:0];
        if (sat_hi) begin
            out_data_d = {1'b0, {(W_IN - 1){1'b1}}};
        end else if (sat_lo) begin
            out_data_d = {1'b1, {(W_IN - 1){1'b0}}};
        end
    end

`ifdef MAC_PREACTIVATION_SAT_FLAG_EN
    logic sat_q;
    assign out_sat = sat_q;
`endif

    // Control FSM; clear outranks everything except reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MAC_PREACTIVATION_SAT_FLAG_EN
            sat_q       <= 1'b0;
`endif
        end else if (clear) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            state_q     <= ST_OUT;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= out_data_d;
`ifdef MAC_PREACTIVATION_SAT_FLAG_EN
                            sat_q       <= sat_hi | sat_lo;
`endif
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_ACC;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_preactivation.sv
// Directed self-checking bench for mac_preactivation (default parameters, Q2.6 operands, Q3.5 output).
module tb_mac_preactivation;

    logic       clock = 1'b0;
    logic       resetn;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_w;
    logic [7:0] in_bias;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef MAC_PREACTIVATION_SAT_FLAG_EN
    logic       out_sat;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mac_preactivation dut (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MAC_PREACTIVATION_SAT_FLAG_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present n beats (first beat carries bias/x0/w0); optional idle cycles between beats.
    task automatic feed(input int n, input logic [7:0] bias, input logic [7:0] x0, input logic [7:0] w0,
                        input logic [7:0] xr, input logic [7:0] wr, input bit gaps);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_x     = (i == 0) ? x0 : xr;
            in_w     = (i == 0) ? w0 : wr;
            in_bias  = (i == 0) ? bias : 8'h55;
            if (gaps && (i < n - 1) && (i % 3 == 1)) begin
                @(negedge clock);
                in_valid = 1'b0;
                in_x     = 8'h7F;
                in_w     = 8'h7F;
                in_bias  = 8'h7F;
            end
        end
    endtask

    // One cycle after the last beat the result must be valid and input stalled.
    task automatic expect_result(input string tag, input logic [7:0] exp, input bit exp_sat);
        @(negedge clock);
        in_valid = 1'b0;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(exp));
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
`ifdef MAC_PREACTIVATION_SAT_FLAG_EN
        check({tag, ".sat"}, 32'(out_sat), 32'(exp_sat));
`else
        if (exp_sat) begin end
`endif
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, ".pop_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".pop_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [7:0] bias, input logic [7:0] x0, input logic [7:0] w0,
                       input logic [7:0] xr, input logic [7:0] wr, input logic [7:0] exp, input bit exp_sat);
        feed(16, bias, x0, w0, xr, wr, 1'b0);
        expect_result(tag, exp, exp_sat);
        pop(tag);
    endtask

    initial begin
        resetn    = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_bias   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;

        // 16 * (1.0 * 0.125) = 2.0
        run("basic", 8'h00, 8'h40, 8'h08, 8'h40, 8'h08, 8'h40, 1'b0);
        run("bias_only", 8'h20, 8'h00, 8'h11, 8'h00, 8'h22, 8'h20, 1'b0);
        run("rnd_pos", 8'h00, 8'h01, 8'h40, 8'h00, 8'h7F, 8'h01, 1'b0);
        run("rnd_neg", 8'h00, 8'hFF, 8'h40, 8'h00, 8'h7F, 8'h00, 1'b0);
        // 0.5 + 1.0*-1.0 = -0.5 -> 0xF0
        run("mixed", 8'h10, 8'h40, 8'hC0, 8'h00, 8'h33, 8'hF0, 1'b0);
        run("sat_pos", 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
        run("sat_neg", 8'h00, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 1'b1);
        // Boundaries: R=127 and R=-128 pass, R=128 and R=-129 clip
        run("edge_max", 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 1'b0);
        run("edge_over", 8'h7F, 8'h02, 8'h40, 8'h00, 8'h00, 8'h7F, 1'b1);
        run("edge_min", 8'h80, 8'hFF, 8'h40, 8'h00, 8'h00, 8'h80, 1'b0);
        run("edge_under", 8'h80, 8'hFF, 8'h41, 8'h00, 8'h00, 8'h80, 1'b1);

        feed(16, 8'h00, 8'h40, 8'h08, 8'h40, 8'h08, 1'b1);
        expect_result("gaps", 8'h40, 1'b0);
        pop("gaps");

        // Backpressure with beats offered while the result is held
        feed(16, 8'h00, 8'h40, 8'h08, 8'h40, 8'h08, 1'b0);
        expect_result("bp", 8'h40, 1'b0);
        in_valid = 1'b1;
        in_x     = 8'h40;
        in_w     = 8'h08;
        in_bias  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_data", 32'(out_data), 32'h40);
            check("bp.hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp.release_valid", 32'(out_valid), 32'd0);
        check("bp.release_ready", 32'(in_ready), 32'd1);
        run("bp.next", 8'h00, 8'h40, 8'h08, 8'h40, 8'h08, 8'h40, 1'b0);

        // Abort mid-vector with clear (the beat offered alongside is dropped)
        feed(7, 8'h20, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0);
        @(negedge clock);
        clear    = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr.valid", 32'(out_valid), 32'd0);
        check("clr.ready", 32'(in_ready), 32'd1);
        run("clr.next", 8'h00, 8'h40, 8'h08, 8'h40, 8'h08, 8'h40, 1'b0);

        // clear while a result is held
        feed(16, 8'h00, 8'h01, 8'h40, 8'h00, 8'h00, 1'b0);
        expect_result("clr_out", 8'h01, 1'b0);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_out.valid", 32'(out_valid), 32'd0);
        check("clr_out.ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-vector
        feed(7, 8'h20, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.data", 32'(out_data), 32'd0);
        check("arst.ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        run("arst.next", 8'h00, 8'h40, 8'h08, 8'h40, 8'h08, 8'h40, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_preactivation.md
Name: mac_preactivation

Overview:
- Streaming multiply-accumulate stage that sits directly upstream of the shift-based tanh PLA.
- Each result is one pre-activation sum(x_i*w_i) + bias over VEC_LEN beats.
- Rounds and saturates the sum into the PLA's signed fixed-point input format (W_IN bits, IN_I integer bits including sign).
- Presents the result on a valid/ready output; the PLA input consumes it.

Parameters:
- W_X, 8: signed data operand width.
- X_F, 6: data operand fractional bits (default Q2.6).
- W_W, 8: signed weight operand width.
- W_F, 6: weight fractional bits (default Q2.6).
- VEC_LEN, 16: beats per pre-activation; must be >= 2.
- W_IN, 8: output width; equals the PLA's W_IN.
- IN_I, 3: output integer bits including sign; output fractional bits IN_F = W_IN-IN_I. Constraint: X_F+W_F >= IN_F.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; discards partial sum and any held result.
- in_valid  in  1  beat valid.
- in_ready  out  1  stage can accept a beat.
- in_x  in  W_X  signed data operand.
- in_w  in  W_W  signed weight.
- in_bias  in  W_IN  signed bias in output format; sampled only on beat 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W_IN  signed saturated pre-activation.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `resetn` is asynchronous and active-low.
- Reset values: state=ACC, beat count=0, accumulator=0, out_valid=0, out_data=0. in_ready=1 after reset.
- Internal widths:
  - Product is W_X+W_W bits with PF=X_F+W_F fractional bits.
  - Accumulator is W_X+W_W+clog2(VEC_LEN)+1 bits, signed, and never overflows.
  - Bias is sign-extended and left-shifted by SH=PF-IN_F before being added.
- FSM has 2 states:
  - ACC: in_ready=1. A beat is accepted when in_valid&&in_ready.
    - Beat 0: acc <= bias_aligned + x*w.
    - Other beats: acc <= acc + x*w.
    - Count increments per accepted beat.
    - On the accepted beat with count==VEC_LEN-1, the final sum S=acc+x*w is formed combinationally. Next cycle: state=OUT, out_valid=1, out_data=sat(round(S)), count=0.
  - OUT: in_ready=0. out_data and out_valid are held stable until out_valid&&out_ready. On that handshake: out_valid=0 and state=ACC next cycle.
- Latency: result valid 1 cycle after the last beat is accepted. Peak throughput is one result per VEC_LEN+1 cycles.
- Rounding: round-half-up, R=(S + 2^(SH-1)) >>> SH (arithmetic shift). If SH=0, no rounding.
- Saturation: if R > 2^(W_IN-1)-1, out=0x7F (default widths). If R < -2^(W_IN-1), out=0x80. Otherwise out=R[W_IN-1:0].
- Gaps: in_valid low between beats is allowed; count and accumulator are held.
- Handshake and new beat in the same cycle: a beat presented while in OUT is not accepted (in_ready=0), even in the cycle the output handshake completes.
- clear has priority over every other event. Next cycle: count=0, out_valid=0, state=ACC, and any beat presented with clear is dropped. Accumulator contents are don't-care because beat 0 reloads them.
- Reset asserted mid-vector or in OUT: everything returns to reset values immediately. The partial sum is lost, and the next vector starts at beat 0.
- in_x, in_w and in_bias are ignored unless a beat is accepted.

Optional Feature:
- Macro: MAC_PREACTIVATION_SAT_FLAG_EN.
- When defined: adds output port out_sat (1 bit, reset 0). It is registered with out_data, is 1 when saturation clipped the result, and is held with out_data while in OUT.
- When undefined: the port does not exist and the saturation logic is unchanged.

Test Plan:
- Basic sum: bias=0, 16 beats of x=0x40 (1.0), w=0x08 (0.125) -> out_data=0x40 (2.0) with out_valid 1 cycle after beat 16.
- Bias only: in_bias=0x20 (1.0) on beat 0, all x=0 -> out_data=0x20.
- Rounding, positive half: beat 0 x=0x01, w=0x40 (product 64), rest 0, bias 0 -> out_data=0x01.
- Rounding, negative half: same with x=0xFF -> out_data=0x00.
- Saturation: 16 beats of x=0x7F, w=0x7F -> out_data=0x7F. With x=0x80, w=0x7F -> out_data=0x80. With the macro defined, out_sat=1 in both cases.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid and out_data stable, in_ready=0, no beats counted. Raise out_ready -> in_ready=1 next cycle and the next vector's result is correct.
- Abort: accept 7 beats, then pulse clear (and separately pull resetn low) -> out_valid=0, the following full vector (basic sum stimulus) yields exactly 0x40.
